// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and round datapath.
package aes_pkg;

    localparam int unsigned AES_NR_128 = 10;
    localparam int unsigned ROUND_W    = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } kx_state_t;

    // Round constant for a 4-bit round index; indices past the table give zero.
    function automatic logic [7:0] rcon_lookup(input logic [ROUND_W-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (idx == ROUND_W'(i)) begin
                r = RCON[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Word-wide AES S-box: four parallel byte substitutions (SubWord).
module aes_sbox_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t sub_c_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub_c_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                      SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..NR one per rk_valid/rk_ready handshake.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR_128
) (
    input  logic               clk,
    input  logic               reset,
    input  block_t             key,
    input  logic               key_valid,
    output logic               key_ready,
    output block_t             rk,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [ROUND_W-1:0] rk_round,
    output logic               busy
);

    if (NR != AES_NR_128) begin : g_bad_nr
        $error("aes_key_expand supports AES-128 only (NR must be 10)");
    end

    kx_state_t          state_q, state_d;
    block_t             rk_q, rk_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               kready_q, kready_d;

    word_t  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
    block_t next_rk;

    // Next round key from the registered key; RCON indexed by the pre-increment round.
    assign w0  = rk_q[127:96];
    assign w1  = rk_q[95:64];
    assign w2  = rk_q[63:32];
    assign w3  = rk_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox_word u_sbox (
        .word_i  (rot),
        .sub_c_o (sub)
    );

    assign t       = sub ^ {rcon_lookup(round_q), 24'h000000};
    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rk_q     <= '0;
            round_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            kready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            rk_q     <= rk_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            kready_q <= kready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rk_d     = rk_q;
        round_d  = round_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        kready_d = kready_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d  = EMIT;
                    rk_d     = key;
                    round_d  = '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    kready_d = 1'b0;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_q == ROUND_W'(NR)) begin
                        // Last key consumed; rk keeps its stale value while invalid.
                        state_d  = IDLE;
                        round_d  = '0;
                        valid_d  = 1'b0;
                        busy_d   = 1'b0;
                        kready_d = 1'b1;
                    end else begin
                        rk_d    = next_rk;
                        round_d = round_q + ROUND_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign key_ready = kready_q;
    assign rk        = rk_q;
    assign rk_valid  = valid_q;
    assign rk_round  = round_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key schedule vectors.
module tb_aes_key_expand;
    import aes_pkg::*;

    logic         clk;
    logic         reset;
    block_t       key;
    logic         key_valid;
    logic         key_ready;
    block_t       rk;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic         busy;

    int checks;
    int failures;

    localparam block_t KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam block_t KEY_Z_R1  = 128'h62636363626363636263636362636363;

    localparam block_t A1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; key = '0; key_valid = 1'b0; rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rk_valid, busy, key_ready} !== 3'b001 || rk_round !== 4'd0 || rk !== 128'h0) begin
            failures++;
            $display("FAIL reset: valid=%b busy=%b kready=%b round=%0d rk=%h exp 0/0/1/0/0",
                     rk_valid, busy, key_ready, rk_round, rk);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        key = KEY_A; key_valid = 1'b1; rk_ready = 1'b1;
        checks++;
        if (rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL fips_pre_valid: got %b exp 0", rk_valid);
        end
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || key_ready !== 1'b0 || rk_round !== 4'(i) || rk !== A1[i]) begin
                failures++;
                $display("FAIL fips_round%0d: valid=%b busy=%b kready=%b round=%0d rk=%h exp round=%0d rk=%h",
                         i, rk_valid, busy, key_ready, rk_round, rk, i, A1[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_round !== 4'd0) begin
            failures++;
            $display("FAIL fips_end: valid=%b kready=%b busy=%b round=%0d exp 0/1/0/0",
                     rk_valid, key_ready, busy, rk_round);
        end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        int stall;
        int cyc;
        exp_idx = 0; stall = 0; cyc = 0;
        key = KEY_A; key_valid = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        while (exp_idx < 11 && cyc < 400) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(exp_idx) || rk !== A1[exp_idx]) begin
                failures++;
                $display("FAIL bp_round%0d cyc%0d: valid=%b round=%0d rk=%h exp %h",
                         exp_idx, cyc, rk_valid, rk_round, rk, A1[exp_idx]);
            end
            if (exp_idx == 5 && stall < 20) begin
                rk_ready = 1'b0;
                stall++;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            if (rk_ready) exp_idx++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_idx != 11 || rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end: consumed=%0d valid=%b exp 11/0", exp_idx, rk_valid);
        end
        rk_ready = 1'b1;
    endtask

    task automatic test_busy_collision();
        key = KEY_A; key_valid = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk !== A1[i]) begin
                failures++;
                $display("FAIL collide_round%0d: valid=%b round=%0d rk=%h exp %h",
                         i, rk_valid, rk_round, rk, A1[i]);
            end
            key       = KEY_B;
            key_valid = (i >= 3 && i <= 7);
            @(negedge clk);
        end
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL collide_end: valid=%b kready=%b exp 0/1", rk_valid, key_ready);
        end
    endtask

    task automatic test_reset_mid();
        key = KEY_A; key_valid = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            checks++;
            if (rk_round !== 4'(i) || rk !== A1[i]) begin
                failures++;
                $display("FAIL rstmid_round%0d: round=%0d rk=%h exp %h", i, rk_round, rk, A1[i]);
            end
            if (i == 4) reset = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (rk_valid !== 1'b0 || rk_round !== 4'd0 || key_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: valid=%b round=%0d kready=%b busy=%b exp 0/0/1/0",
                     rk_valid, rk_round, key_ready, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        key = KEY_B; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk !== KEY_B) begin
            failures++;
            $display("FAIL rstmid_b_round0: valid=%b round=%0d rk=%h exp %h", rk_valid, rk_round, rk, KEY_B);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk !== KEY_B_R10) begin
            failures++;
            $display("FAIL rstmid_b_round10: valid=%b round=%0d rk=%h exp %h",
                     rk_valid, rk_round, rk, KEY_B_R10);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        key = KEY_A; key_valid = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        key = '0;
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk !== A1[i]) begin
                failures++;
                $display("FAIL b2b_a_round%0d: valid=%b round=%0d rk=%h exp %h",
                         i, rk_valid, rk_round, rk, A1[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: valid=%b kready=%b exp 0/1", rk_valid, key_ready);
        end
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk !== 128'h0) begin
            failures++;
            $display("FAIL b2b_b_round0: valid=%b round=%0d rk=%h exp 0", rk_valid, rk_round, rk);
        end
        key_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rk_round !== 4'd1 || rk !== KEY_Z_R1) begin
            failures++;
            $display("FAIL b2b_b_round1: round=%0d rk=%h exp %h", rk_round, rk, KEY_Z_R1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: valid=%b kready=%b exp 0/1", rk_valid, key_ready);
        end
    endtask

    task automatic test_zero_key();
        key = '0; key_valid = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk !== 128'h0) begin
            failures++;
            $display("FAIL zero_hold0: valid=%b round=%0d rk=%h exp 0", rk_valid, rk_round, rk);
        end
        rk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rk_round !== 4'd1 || rk !== KEY_Z_R1) begin
            failures++;
            $display("FAIL zero_round1: round=%0d rk=%h exp %h", rk_round, rk, KEY_Z_R1);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fips();
        test_backpressure();
        test_busy_collision();
        test_reset_mid();
        test_back_to_back();
        test_zero_key();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
